// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encoding and lamp colour codes for the
//               demand-driven intersection scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        TURN_G  = 3'd2,
        TURN_Y  = 3'd3,
        SIDE_G  = 3'd4,
        SIDE_Y  = 3'd5,
        ALL_RED = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        LAST_MAIN = 2'd0,
        LAST_TURN = 2'd1,
        LAST_SIDE = 2'd2
    } last_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

`default_nettype wire

// File: rtl/traffic_lamp_decode.sv
// ============================================================================
// Module      : traffic_lamp_decode
// Description : Combinational decode of the scheduler phase into the four
//               lamp buses and the pedestrian walk lamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  phase_e     state,
    input  logic       walk_ok,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       walk
);

    always_comb begin
        light_M1 = LAMP_RED;
        light_M2 = LAMP_RED;
        light_MT = LAMP_RED;
        light_S  = LAMP_RED;
        case (state)
            MAIN_G: begin
                light_M1 = LAMP_GRN;
                light_M2 = LAMP_GRN;
            end
            MAIN_Y: begin
                light_M1 = LAMP_YEL;
                light_M2 = LAMP_YEL;
            end
            TURN_G:  light_MT = LAMP_GRN;
            TURN_Y:  light_MT = LAMP_YEL;
            SIDE_G:  light_S  = LAMP_GRN;
            SIDE_Y:  light_S  = LAMP_YEL;
            default: ;
        endcase
        walk = (state == SIDE_G) && walk_ok;
    end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Demand-driven phase FSM with dwell counter, demand latches
//               and emergency preemption back to main green.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 10,
    parameter int TURN_GREEN = 3,
    parameter int YELLOW     = 2,
    parameter int ALL_RED_T  = 1,
    parameter int PED_WALK   = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_turn,
    input  logic       req_side,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       walk,
    output logic [2:0] phase,
    output logic       emerg_active
);

    localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] C_TURN = CNT_W'(TURN_GREEN);
    localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALL_RED_T);
    localparam logic [CNT_W-1:0] C_WALK = CNT_W'(PED_WALK);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SAT  = '1;

    phase_e           state_q, state_d;
    last_e            last_q, last_d;
    logic [CNT_W-1:0] d_q, d_d;
    logic             turn_pend_q, turn_pend_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             ped_serve_q, ped_serve_d;
    logic             preempt_q, preempt_d;
    logic             w_changed, w_enter_turn, w_enter_side, w_walk_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MAIN_G;
            last_q      <= LAST_MAIN;
            d_q         <= C_ONE;
            turn_pend_q <= 1'b0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            ped_serve_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            d_q         <= d_d;
            turn_pend_q <= turn_pend_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            ped_serve_q <= ped_serve_d;
            preempt_q   <= preempt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_G: if (d_q >= C_MIN && (turn_pend_q || side_pend_q) && !emerg)
                        state_d = MAIN_Y;
            MAIN_Y, TURN_Y, SIDE_Y:
                    if (d_q == C_YEL) state_d = ALL_RED;
            TURN_G: if (d_q == C_TURN || emerg) state_d = TURN_Y;
            SIDE_G: if (emerg || (d_q >= C_MIN && (!req_side || d_q == C_MAX)))
                        state_d = SIDE_Y;
            ALL_RED: if (d_q == C_AR) begin
                if (emerg)                                    state_d = MAIN_G;
                else if (last_q == LAST_MAIN && turn_pend_q)  state_d = TURN_G;
                else if (last_q != LAST_SIDE && side_pend_q)  state_d = SIDE_G;
                else                                          state_d = MAIN_G;
            end
            default: state_d = MAIN_G;
        endcase

        w_changed    = (state_d != state_q);
        w_enter_turn = w_changed && (state_d == TURN_G);
        w_enter_side = w_changed && (state_d == SIDE_G);

        last_d = last_q;
        if (w_changed) begin
            case (state_q)
                MAIN_G:  last_d = LAST_MAIN;
                TURN_G:  last_d = LAST_TURN;
                SIDE_G:  last_d = LAST_SIDE;
                default: ;
            endcase
        end

        // The preempt flag covers the clearance that follows an emergency exit.
        preempt_d = preempt_q;
        if (w_changed && emerg && (state_q == TURN_G || state_q == SIDE_G))
            preempt_d = 1'b1;
        else if (w_changed && state_q == ALL_RED)
            preempt_d = 1'b0;

        // A request arriving on the entry edge is served by that green.
        turn_pend_d = (turn_pend_q || req_turn) && !w_enter_turn;
        side_pend_d = (side_pend_q || req_side || ped_req) && !w_enter_side;
        ped_pend_d  = (ped_pend_q || ped_req) && !w_enter_side;
        ped_serve_d = w_enter_side ? (ped_pend_q || ped_req) : ped_serve_q;

        if (w_changed)         d_d = C_ONE;
        else if (d_q == C_SAT) d_d = d_q;
        else                   d_d = d_q + C_ONE;
    end

    always_comb begin
        w_walk_ok    = ped_serve_q && (d_q <= C_WALK);
        emerg_active = emerg || preempt_q;
        phase        = state_q;
    end

    traffic_lamp_decode u_decode (
        .state    (state_q),
        .walk_ok  (w_walk_ok),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .walk     (walk)
    );

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed and randomized stimulus against a cycle-level
//               behavioural model of the phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int TURN_T = 3;
    localparam int YEL_T = 2;
    localparam int AR_T = 1;
    localparam int WALK_T = 3;
    localparam int D_SAT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_turn = 1'b0, req_side = 1'b0, ped_req = 1'b0, emerg = 1'b0;
    logic [2:0] light_M1, light_M2, light_MT, light_S, phase;
    logic       walk, emerg_active;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_phase_scheduler #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .TURN_GREEN(TURN_T),
        .YELLOW(YEL_T), .ALL_RED_T(AR_T), .PED_WALK(WALK_T), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req_turn(req_turn), .req_side(req_side),
        .ped_req(ped_req), .emerg(emerg), .light_M1(light_M1),
        .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .walk(walk), .phase(phase), .emerg_active(emerg_active)
    );

    always #5 clk = ~clk;

    // Reference model: phase name, cycles spent in it, previous green, demands
    phase_e ms;
    int     md;
    int     m_last;     // 0 main, 1 turn, 2 side
    bit     m_tp, m_sp, m_pp, m_walk_on, m_pre;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] lamps_of(input phase_e s);
        logic [2:0] r, y, g;
        r = 3'b100; y = 3'b010; g = 3'b001;
        case (s)
            MAIN_G:  return {g, g, r, r};
            MAIN_Y:  return {y, y, r, r};
            TURN_G:  return {r, r, g, r};
            TURN_Y:  return {r, r, y, r};
            SIDE_G:  return {r, r, r, g};
            SIDE_Y:  return {r, r, r, y};
            default: return {r, r, r, r};
        endcase
    endfunction

    task automatic model_reset();
        ms = MAIN_G; md = 1; m_last = 0;
        m_tp = 0; m_sp = 0; m_pp = 0; m_walk_on = 0; m_pre = 0;
    endtask

    task automatic model_step(input bit rt, input bit rs, input bit pr, input bit em);
        phase_e ns;
        ns = ms;
        case (ms)
            MAIN_G:  if (md >= MIN_G && (m_tp || m_sp) && !em) ns = MAIN_Y;
            TURN_G:  if (md == TURN_T || em) ns = TURN_Y;
            SIDE_G:  if (em || (md >= MIN_G && (!rs || md == MAX_G))) ns = SIDE_Y;
            ALL_RED: if (md == AR_T) begin
                if (em) ns = MAIN_G;
                else if (m_last == 0) ns = m_tp ? TURN_G : (m_sp ? SIDE_G : MAIN_G);
                else if (m_last == 1) ns = m_sp ? SIDE_G : MAIN_G;
                else ns = MAIN_G;
            end
            default: if (md == YEL_T) ns = ALL_RED;
        endcase
        if (ns != ms) begin
            if (ms == MAIN_G) m_last = 0;
            if (ms == TURN_G) m_last = 1;
            if (ms == SIDE_G) m_last = 2;
            if (em && (ms == TURN_G || ms == SIDE_G)) m_pre = 1;
            if (ms == ALL_RED) m_pre = 0;
        end
        m_tp = (m_tp | rt) & !(ns == TURN_G && ms != TURN_G);
        if (ns == SIDE_G && ms != SIDE_G) begin
            m_walk_on = m_pp | pr;
            m_sp = 0;
            m_pp = 0;
        end else begin
            m_sp = m_sp | rs | pr;
            m_pp = m_pp | pr;
        end
        md = (ns != ms) ? 1 : ((md < D_SAT) ? md + 1 : md);
        ms = ns;
    endtask

    task automatic compare_outputs();
        bit exp_walk;
        exp_walk = (ms == SIDE_G) && m_walk_on && (md <= WALK_T);
        check_val("phase", 16'(phase), 16'(ms));
        check_val("lamps", 16'({light_M1, light_M2, light_MT, light_S}), 16'(lamps_of(ms)));
        check_val("walk", 16'(walk), 16'(exp_walk));
        check_val("emerg_active", 16'(emerg_active), 16'(emerg | m_pre));
    endtask

    task automatic run_cycle(input bit rt, input bit rs, input bit pr, input bit em);
        req_turn = rt; req_side = rs; ped_req = pr; emerg = em;
        @(posedge clk);
        model_step(rt, rs, pr, em);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0);
    endtask

    task automatic wait_phase(input phase_e target, input int budget);
        bit found;
        found = (ms == target);
        for (int i = 0; i < budget && !found; i++) begin
            run_cycle(0, 0, 0, 0);
            found = (ms == target);
        end
        check_val("wait_phase_reached", 16'(found), 16'd1);
    endtask

    task automatic reset_pulse();
        req_turn = 0; req_side = 0; ped_req = 0; emerg = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit hold_side;
        int emerg_left;
        model_reset();
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;

        idle(50);

        idle(10);
        run_cycle(1, 0, 0, 0);
        idle(20);

        for (int i = 0; i < 40; i++) run_cycle(0, 1, 0, 0);
        idle(20);

        run_cycle(0, 0, 1, 0);
        idle(20);

        run_cycle(0, 1, 0, 0);
        wait_phase(SIDE_G, 40);
        run_cycle(1, 0, 0, 1);
        for (int i = 0; i < 9; i++) run_cycle(0, 0, 0, 1);
        idle(25);

        run_cycle(1, 0, 0, 0);
        wait_phase(TURN_Y, 40);
        reset_pulse();
        run_cycle(0, 1, 0, 0);
        idle(30);

        hold_side = 0;
        emerg_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 30) == 0) hold_side = !hold_side;
            if (emerg_left > 0) emerg_left--;
            else if ($urandom_range(0, 150) == 0) emerg_left = $urandom_range(1, 12);
            if ($urandom_range(0, 800) == 0) reset_pulse();
            run_cycle($urandom_range(0, 19) == 0,
                      hold_side || ($urandom_range(0, 9) == 0),
                      $urandom_range(0, 24) == 0,
                      emerg_left > 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
